// File: rtl/mem_request_agent_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_agent_if
// Brief    : Request/return bus between the traffic agent and the memory model.
// Revision : 1.0
// ============================================================================
interface mem_request_agent_if;
    logic [15:0] wr_address;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] wr_ret_address;
    logic        wr_ret_ack;
    logic [15:0] rd_address;
    logic        rd_en;
    logic [15:0] rd_ret_data;
    logic [15:0] rd_ret_address;
    logic        rd_ret_ack;

    modport master (
        output wr_address, wr_en, wr_data, rd_address, rd_en,
        input  wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack
    );

    modport slave (
        input  wr_address, wr_en, wr_data, rd_address, rd_en,
        output wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_request_agent.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_agent
// Brief    : Writes NUM_REQ words, drains acks, reads them back and checks data.
// Revision : 1.0
// ============================================================================
module mem_request_agent #(
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          NUM_REQ         = 16,
    parameter logic [15:0] BASE_ADDR       = 16'h0,
    parameter int          TIMEOUT         = 1023
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           start,
    mem_request_agent_if.master mem,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         err_count
);
    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_WRITE  = 3'd1;
    localparam logic [2:0]  c_ST_WDRAIN = 3'd2;
    localparam logic [2:0]  c_ST_READ   = 3'd3;
    localparam logic [2:0]  c_ST_RDRAIN = 3'd4;
    localparam logic [2:0]  c_ST_DONE   = 3'd5;
    localparam logic [15:0] c_DATA_KEY  = 16'hA5A5;
    localparam logic [16:0] c_NUM_REQ   = 17'(NUM_REQ);
    localparam logic [3:0]  c_MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [31:0] c_TIMEOUT   = 32'(TIMEOUT);
    localparam logic [MAX_OUTSTANDING-1:0] c_ONE = MAX_OUTSTANDING'(1);

    logic [2:0]                 r_state;
    logic [MAX_OUTSTANDING-1:0] r_valid;
    logic [15:0]                r_tag [MAX_OUTSTANDING];
    logic [16:0]                r_index;
    logic [31:0]                r_tcnt;
    logic                       r_wr_en, r_rd_en;
    logic [15:0]                r_wr_address, r_wr_data, r_rd_address;
    logic                       r_busy, r_done, r_error;
    logic [15:0]                r_err_count;

    logic                       w_wphase, w_rphase, w_active, w_empty;
    logic [MAX_OUTSTANDING-1:0] w_wr_hit, w_rd_hit, w_free_oh, w_clr_oh, w_valid_nxt;
    logic [3:0]                 w_count;
    logic                       w_wr_ok, w_wr_bad, w_rd_ok, w_rd_bad, w_rd_data_bad;
    logic                       w_issue, w_last, w_timeout;
    logic [15:0]                w_issue_addr;
    logic [1:0]                 w_err_inc;
    logic [16:0]                w_err_sum;
    logic [31:0]                w_tcnt_nxt;

    always_comb begin
        w_wphase = (r_state == c_ST_WRITE) || (r_state == c_ST_WDRAIN);
        w_rphase = (r_state == c_ST_READ)  || (r_state == c_ST_RDRAIN);
        w_active = w_wphase || w_rphase;
        w_empty  = (r_valid == '0);
        w_count  = '0;
        w_wr_hit = '0;
        w_rd_hit = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            w_count     = w_count + {3'b000, r_valid[i]};
            w_wr_hit[i] = r_valid[i] && (r_tag[i] == mem.wr_ret_address);
            w_rd_hit[i] = r_valid[i] && (r_tag[i] == mem.rd_ret_address);
        end
        // Lowest-index set bit isolation picks the free slot and the retiring match.
        w_free_oh     = ~r_valid & (r_valid + c_ONE);
        w_wr_ok       = w_wphase && mem.wr_ret_ack && (|w_wr_hit);
        w_rd_ok       = w_rphase && mem.rd_ret_ack && (|w_rd_hit);
        w_wr_bad      = w_active && mem.wr_ret_ack && !w_wr_ok;
        w_rd_bad      = w_active && mem.rd_ret_ack && !w_rd_ok;
        w_rd_data_bad = w_rd_ok && (mem.rd_ret_data != (mem.rd_ret_address ^ c_DATA_KEY));
        w_clr_oh      = (w_wr_ok ? (w_wr_hit & (~w_wr_hit + c_ONE)) : '0)
                      | (w_rd_ok ? (w_rd_hit & (~w_rd_hit + c_ONE)) : '0);
        w_tcnt_nxt    = (w_empty || mem.wr_ret_ack || mem.rd_ret_ack) ? 32'd0 : r_tcnt + 32'd1;
        w_timeout     = w_active && (w_tcnt_nxt >= c_TIMEOUT);
        // Issue decision uses the registered occupancy, so a same-cycle retire cannot free a slot.
        w_issue       = ((r_state == c_ST_WRITE) || (r_state == c_ST_READ))
                      && (r_index < c_NUM_REQ) && (w_count < c_MAX_OUT) && !w_timeout;
        w_last        = (r_index == c_NUM_REQ - 17'd1);
        w_issue_addr  = BASE_ADDR + r_index[15:0];
        w_valid_nxt   = (r_valid & ~w_clr_oh) | (w_issue ? w_free_oh : '0);
        w_err_inc     = {1'b0, w_wr_bad} + {1'b0, w_rd_bad || w_rd_data_bad};
        w_err_sum     = {1'b0, r_err_count} + {15'd0, w_err_inc};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (w_issue && w_free_oh[i]) begin
                r_tag[i] <= w_issue_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_valid      <= '0;
            r_index      <= '0;
            r_tcnt       <= '0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_rd_address <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state     <= c_ST_WRITE;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_count <= '0;
                        r_index     <= '0;
                        r_tcnt      <= '0;
                        r_valid     <= '0;
                    end
                end
                c_ST_WRITE, c_ST_WDRAIN, c_ST_READ, c_ST_RDRAIN: begin
                    r_valid <= w_valid_nxt;
                    r_tcnt  <= w_tcnt_nxt;
                    if (w_err_inc != 2'd0) begin
                        r_error     <= 1'b1;
                        r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
                    end
                    if (w_issue) begin
                        r_index <= r_index + 17'd1;
                        if (r_state == c_ST_WRITE) begin
                            r_wr_en      <= 1'b1;
                            r_wr_address <= w_issue_addr;
                            r_wr_data    <= w_issue_addr ^ c_DATA_KEY;
                        end else begin
                            r_rd_en      <= 1'b1;
                            r_rd_address <= w_issue_addr;
                        end
                    end
                    if (w_timeout) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_valid <= '0;
                    end else begin
                        case (r_state)
                            c_ST_WRITE:  if (w_issue && w_last) r_state <= c_ST_WDRAIN;
                            c_ST_WDRAIN: if (w_empty) begin
                                r_state <= c_ST_READ;
                                r_index <= '0;
                            end
                            c_ST_READ:   if (w_issue && w_last) r_state <= c_ST_RDRAIN;
                            c_ST_RDRAIN: if (w_empty) begin
                                r_state <= c_ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mem.wr_en      = r_wr_en;
    assign mem.wr_address = r_wr_address;
    assign mem.wr_data    = r_wr_data;
    assign mem.rd_en      = r_rd_en;
    assign mem.rd_address = r_rd_address;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign err_count      = r_err_count;
endmodule
`default_nettype wire
